// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer sequencer and its handshake fan-out.
package layer_pkg;

    typedef logic signed [15:0] word_t;
    typedef logic [7:0]         byte_t;

    typedef enum logic [3:0] {
        IDLE,
        BCAST,
        COLLECT,
        OUT,
        DLOAD,
        DSEND,
        GATHER,
        SUM,
        ERR
    } layer_state_t;

    // Clamp a wide signed sum into the 16-bit signed range.
    function automatic word_t sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/handshake_fanout.sv
// Broadcasts one latched payload to M ready/valid sinks; each sink's valid
// drops after its own transfer and the group reports done on the final one.
module handshake_fanout #(
    parameter int M = 2,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic [M-1:0] i_ready,
    output logic [M-1:0] o_valid,
    output logic [W-1:0] o_data,
    output logic         o_done
);

    logic [M-1:0] r_pend;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_pend <= '1;
            r_data <= i_data;
        end else begin
            r_pend <= r_pend & ~i_ready;
        end
    end

    assign o_valid = r_pend;
    assign o_data  = r_data;
    // Mask is only non-zero while the owning state is active.
    assign o_done  = (r_pend != '0) && ((r_pend & ~i_ready) == '0);

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: broadcasts an operand to M nodes, gathers their products,
// and in training distributes deltas and sums node feedback into an error vector.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        train,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  byte_t [N-1:0]               input_data,
    output logic                        node_train,
    output logic [M-1:0]                operand_valid,
    input  logic [M-1:0]                operand_ready,
    output byte_t [N-1:0]               operand_data,
    input  logic [M-1:0]                product_valid,
    output logic [M-1:0]                product_ready,
    input  logic [M-1:0][15:0]          product_data,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [M-1:0][15:0]          output_data,
    input  logic                        delta_in_valid,
    output logic                        delta_in_ready,
    input  logic [M-1:0][15:0]          delta_in_data,
    output logic [M-1:0]                delta_valid,
    input  logic [M-1:0]                delta_ready,
    output logic [M-1:0][15:0]          delta_data,
    input  logic [M-1:0]                feedback_valid,
    output logic [M-1:0]                feedback_ready,
    input  logic [M-1:0][N-1:0][15:0]   feedback_data,
    output logic                        error_valid,
    input  logic                        error_ready,
    output logic [N-1:0][15:0]          error_data
);

    localparam int AW = 16 + $clog2(M) + 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    layer_state_t r_state, w_next;

    logic                      r_train;
    logic [M-1:0]              r_pgot, r_fgot;
    logic [M-1:0][15:0]        r_prod;
    logic [M-1:0][N-1:0][15:0] r_fb;
    logic signed [AW-1:0]      r_acc [N];
    logic signed [AW-1:0]      w_acc_nxt [N];
    logic [CW-1:0]             r_cnt;
    logic [N-1:0][15:0]        r_err;

    logic         w_op_load, w_op_done, w_dl_load, w_dl_done;
    logic [M-1:0] w_ptake, w_ftake;

    assign input_ready    = (r_state == IDLE);
    assign delta_in_ready = (r_state == DLOAD);
    assign output_valid   = (r_state == OUT);
    assign error_valid    = (r_state == ERR);
    assign product_ready  = (r_state == COLLECT) ? ~r_pgot : '0;
    assign feedback_ready = (r_state == GATHER)  ? ~r_fgot : '0;
    assign w_ptake        = product_valid & product_ready;
    assign w_ftake        = feedback_valid & feedback_ready;
    assign w_op_load      = input_valid && input_ready;
    assign w_dl_load      = delta_in_valid && delta_in_ready;
    assign node_train     = r_train;
    assign output_data    = r_prod;
    assign error_data     = r_err;

    handshake_fanout #(.M(M), .W(N*8)) u_op_fanout (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_op_load),
        .i_data  (input_data),
        .i_ready (operand_ready),
        .o_valid (operand_valid),
        .o_data  (operand_data),
        .o_done  (w_op_done)
    );

    handshake_fanout #(.M(M), .W(M*16)) u_dl_fanout (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_dl_load),
        .i_data  (delta_in_data),
        .i_ready (delta_ready),
        .o_valid (delta_valid),
        .o_data  (delta_data),
        .o_done  (w_dl_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (input_valid)                  w_next = BCAST;
            BCAST:   if (w_op_done)                    w_next = COLLECT;
            COLLECT: if (&(r_pgot | w_ptake))          w_next = OUT;
            OUT:     if (output_ready)                 w_next = r_train ? DLOAD : IDLE;
            DLOAD:   if (delta_in_valid)               w_next = DSEND;
            DSEND:   if (w_dl_done)                    w_next = GATHER;
            GATHER:  if (&(r_fgot | w_ftake))          w_next = SUM;
            SUM:     if (r_cnt == LAST)                w_next = ERR;
            ERR:     if (error_ready)                  w_next = IDLE;
            default:                                   w_next = IDLE;
        endcase
    end

    // Feedback is sign-extended before accumulation so the sum cannot wrap.
    always_comb begin
        for (int n = 0; n < N; n++)
            w_acc_nxt[n] = r_acc[n] + AW'($signed(r_fb[r_cnt][n]));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_train <= 1'b0;
            r_pgot  <= '0;
            r_fgot  <= '0;
            r_prod  <= '0;
            r_fb    <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            for (int n = 0; n < N; n++) r_acc[n] <= '0;
        end else begin
            if (w_op_load) r_train <= train;

            if (r_state == COLLECT) begin
                r_pgot <= r_pgot | w_ptake;
                for (int m = 0; m < M; m++)
                    if (w_ptake[m]) r_prod[m] <= product_data[m];
            end else begin
                r_pgot <= '0;
            end

            if (r_state == GATHER) begin
                r_fgot <= r_fgot | w_ftake;
                r_cnt  <= '0;
                for (int n = 0; n < N; n++) r_acc[n] <= '0;
                for (int m = 0; m < M; m++)
                    if (w_ftake[m]) r_fb[m] <= feedback_data[m];
            end else begin
                r_fgot <= '0;
            end

            if (r_state == SUM) begin
                r_cnt <= r_cnt + 1'b1;
                for (int n = 0; n < N; n++) begin
                    r_acc[n] <= w_acc_nxt[n];
                    if (r_cnt == LAST) r_err[n] <= sat16(32'(w_acc_nxt[n]));
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (N=2, M=2): a vector table of full
// transactions plus hand-written staggered, backpressure and reset sequences.
module tb_layer_sequencer;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   train = 1'b0;
    logic                   input_valid = 1'b0;
    logic                   input_ready;
    logic [1:0][7:0]        input_data = '0;
    logic                   node_train;
    logic [1:0]             operand_valid;
    logic [1:0]             operand_ready = '0;
    logic [1:0][7:0]        operand_data;
    logic [1:0]             product_valid = '0;
    logic [1:0]             product_ready;
    logic [1:0][15:0]       product_data = '0;
    logic                   output_valid;
    logic                   output_ready = 1'b0;
    logic [1:0][15:0]       output_data;
    logic                   delta_in_valid = 1'b0;
    logic                   delta_in_ready;
    logic [1:0][15:0]       delta_in_data = '0;
    logic [1:0]             delta_valid;
    logic [1:0]             delta_ready = '0;
    logic [1:0][15:0]       delta_data;
    logic [1:0]             feedback_valid = '0;
    logic [1:0]             feedback_ready;
    logic [1:0][1:0][15:0]  feedback_data = '0;
    logic                   error_valid;
    logic                   error_ready = 1'b0;
    logic [1:0][15:0]       error_data;

    int n_vec  = 0;
    int n_miss = 0;

    layer_sequencer #(.N(2), .M(2)) dut (
        .clock(clock), .reset(reset), .train(train),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .node_train(node_train),
        .operand_valid(operand_valid), .operand_ready(operand_ready), .operand_data(operand_data),
        .product_valid(product_valid), .product_ready(product_ready), .product_data(product_data),
        .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
        .delta_in_valid(delta_in_valid), .delta_in_ready(delta_in_ready), .delta_in_data(delta_in_data),
        .delta_valid(delta_valid), .delta_ready(delta_ready), .delta_data(delta_data),
        .feedback_valid(feedback_valid), .feedback_ready(feedback_ready), .feedback_data(feedback_data),
        .error_valid(error_valid), .error_ready(error_ready), .error_data(error_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        trn;
        logic [7:0]  in0, in1;
        logic [15:0] p0, p1;
        logic [15:0] d0, d1;
        logic [15:0] f00, f01, f10, f11;
        int          dly1;
        int          hold;
        logic [15:0] e0, e1;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_input(input vec_t v);
        @(negedge clock);
        chk("idle input_ready", 64'(input_ready), 64'd1);
        train = v.trn;
        input_data[0] = v.in0;
        input_data[1] = v.in1;
        input_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        input_valid = 1'b0;
        chk("node_train latched", 64'(node_train), 64'(v.trn));
    endtask

    // Node 0 ready at once, node 1 ready dly1 cycles later.
    task automatic do_bcast(input vec_t v);
        int c0 = 0, c1 = 0, bad = 0;
        chk("operand_valid cycle1", 64'(operand_valid), 64'd3);
        for (int k = 0; k < 40; k++) begin
            operand_ready[0] = 1'b1;
            operand_ready[1] = (k >= v.dly1);
            if (operand_valid == 2'b00) break;
            c0 += int'(operand_valid[0]);
            c1 += int'(operand_valid[1]);
            if (product_ready != 2'b00) bad++;
            if (operand_data !== {v.in1, v.in0}) bad++;
            @(negedge clock);
        end
        operand_ready = '0;
        chk("operand_valid0 cycles", 64'(c0), 64'd1);
        chk("operand_valid1 cycles", 64'(c1), 64'(v.dly1 + 1));
        chk("bcast ready/data", 64'(bad), 64'd0);
        chk("collect entered", 64'(product_ready), 64'd3);
    endtask

    task automatic do_collect(input vec_t v);
        product_data[0] = v.p0;
        product_data[1] = v.p1;
        product_valid = 2'b11;
        @(posedge clock);
        @(negedge clock);
        product_valid = 2'b00;
        chk("output_valid latency", 64'(output_valid), 64'd1);
    endtask

    task automatic do_out(input vec_t v);
        int bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            output_ready = 1'b0;
            if (!output_valid || output_data !== {v.p1, v.p0}) bad++;
            @(negedge clock);
        end
        chk("output hold stable", 64'(bad), 64'd0);
        chk("output_data", 64'(output_data), 64'({v.p1, v.p0}));
        output_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        output_ready = 1'b0;
        chk("output single transfer", 64'(output_valid), 64'd0);
        chk("after out delta_in_ready", 64'(delta_in_ready), 64'(v.trn));
        chk("after out input_ready", 64'(input_ready), 64'(!v.trn));
    endtask

    task automatic do_delta(input vec_t v);
        delta_in_data[0] = v.d0;
        delta_in_data[1] = v.d1;
        delta_in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        delta_in_valid = 1'b0;
        chk("delta_valid", 64'(delta_valid), 64'd3);
        chk("delta_data", 64'(delta_data), 64'({v.d1, v.d0}));
        delta_ready = 2'b11;
        @(posedge clock);
        @(negedge clock);
        delta_ready = 2'b00;
        chk("gather entered", 64'({delta_valid, feedback_ready}), 64'd3);
    endtask

    task automatic do_gather_err(input vec_t v);
        int lat = -1;
        feedback_data[0][0] = v.f00;
        feedback_data[0][1] = v.f01;
        feedback_data[1][0] = v.f10;
        feedback_data[1][1] = v.f11;
        feedback_valid = 2'b11;
        @(posedge clock);
        @(negedge clock);
        feedback_valid = 2'b00;
        for (int k = 0; k < 20; k++) begin
            if (error_valid) begin lat = k; break; end
            @(negedge clock);
        end
        chk("error_valid latency", 64'(lat), 64'd2);
        chk("error_data", 64'(error_data), 64'({v.e1, v.e0}));
        error_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        error_ready = 1'b0;
        chk("after err idle", 64'({error_valid, input_ready}), 64'd1);
    endtask

    task automatic run_txn(input vec_t v);
        send_input(v);
        do_bcast(v);
        do_collect(v);
        do_out(v);
        if (v.trn) begin
            do_delta(v);
            do_gather_err(v);
        end
    endtask

    vec_t tbl [6];

    initial begin
        //        trn  in0    in1    p0        p1        d0        d1        f00       f01       f10       f11       dly hold e0        e1
        tbl[0] = '{1'b0, 8'h10, 8'h20, 16'h0100, 16'hFF00, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,    16'h0,    0, 0, 16'h0,    16'h0};
        tbl[1] = '{1'b1, 8'h01, 8'h02, 16'h1234, 16'h0001, 16'h0040, 16'hFFC0, 16'd100,  16'd200,  16'd50,   16'hFED4, 0, 0, 16'd150,  16'hFF9C};
        tbl[2] = '{1'b1, 8'h33, 8'h44, 16'h0002, 16'h0003, 16'h0001, 16'h0002, 16'd30000,16'h8AD0, 16'd10000,16'hD8F0, 0, 0, 16'h7FFF, 16'h8000};
        tbl[3] = '{1'b0, 8'hA5, 8'h5A, 16'hAAAA, 16'h5555, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,    16'h0,    3, 0, 16'h0,    16'h0};
        tbl[4] = '{1'b0, 8'hFF, 8'h00, 16'h7FFF, 16'h8000, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0,    16'h0,    0, 5, 16'h0,    16'h0};
        tbl[5] = '{1'b1, 8'h0F, 8'hF0, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 2, 2, 16'h8000, 16'h7FFF};

        #2;
        chk("reset valids", 64'({operand_valid, product_ready, output_valid, delta_in_ready,
                                 delta_valid, feedback_ready, error_valid}), 64'd0);
        chk("reset input_ready", 64'(input_ready), 64'd1);
        chk("reset data", 64'({operand_data, node_train}), 64'd0);
        chk("reset out/err data", 64'({output_data, error_data}), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Reset in the middle of GATHER with one feedback already captured.
        send_input(tbl[1]);
        do_bcast(tbl[1]);
        do_collect(tbl[1]);
        do_out(tbl[1]);
        do_delta(tbl[1]);
        feedback_data[0][0] = 16'h1111;
        feedback_data[0][1] = 16'h2222;
        feedback_valid = 2'b01;
        @(posedge clock);
        @(negedge clock);
        feedback_valid = 2'b00;
        #2 reset = 1'b0;
        #1;
        chk("mid-reset valids", 64'({operand_valid, product_ready, output_valid, delta_in_ready,
                                    delta_valid, feedback_ready, error_valid}), 64'd0);
        chk("mid-reset input_ready", 64'(input_ready), 64'd1);
        chk("mid-reset data", 64'({output_data, delta_data, error_data}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        run_txn(tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences a layer of `M` `node` instances that share one operand vector. Forward path: accepts one input vector, broadcasts it to every node, gathers the `M` products and presents them as one output vector. In training it continues with a backward path: accepts a per-node delta vector, distributes each delta to its node, collects every node's `N`-wide feedback, and sums the feedback across nodes into one saturated upstream error vector. Sits between adjacent layers, so the nodes never see inter-layer handshakes directly.

## Interface
- `N`, default 2: inputs per node (operand vector width, in elements).
- `M`, default 2: nodes in the layer.
- `clock` input 1: the only clock.
- `reset` input 1: asynchronous, active-low.
- `train` input 1: sampled at input acceptance; selects training for that transaction.
- `input_valid` / `input_ready`: input / output, 1 bit each; handshake for `input_data`.
- `input_data` input `[N-1:0][7:0]`: operand vector.
- `node_train` output 1: latched `train`, driven to all nodes.
- `operand_valid` output `[M-1:0]` / `operand_ready` input `[M-1:0]`: per-node operand handshake.
- `operand_data` output `[N-1:0][7:0]`: broadcast operand vector.
- `product_valid` input `[M-1:0]` / `product_ready` output `[M-1:0]`: per-node product handshake.
- `product_data` input `[M-1:0][15:0]`: node products.
- `output_valid` output 1 / `output_ready` input 1: handshake for `output_data`.
- `output_data` output `[M-1:0][15:0]`: layer output vector.
- `delta_in_valid` input 1 / `delta_in_ready` output 1: handshake for `delta_in_data`.
- `delta_in_data` input `[M-1:0][15:0]`: per-node deltas from downstream.
- `delta_valid` output `[M-1:0]` / `delta_ready` input `[M-1:0]`: per-node delta handshake.
- `delta_data` output `[M-1:0][15:0]`: delta for each node.
- `feedback_valid` input `[M-1:0]` / `feedback_ready` output `[M-1:0]`: per-node feedback handshake.
- `feedback_data` input `[M-1:0][N-1:0][15:0]`: feedback from each node.
- `error_valid` output 1 / `error_ready` input 1: handshake for `error_data`.
- `error_data` output `[N-1:0][15:0]`: upstream error vector.

## Operation
- A transfer on any channel occurs on a clock edge where valid and ready are both 1.
- States: `IDLE`, `BCAST`, `COLLECT`, `OUT`, `DLOAD`, `DSEND`, `GATHER`, `SUM`, `ERR`.
- `IDLE`: `input_ready`=1. On transfer, latch `input_data` into `operand_data` and `train` into `node_train`; set pending mask to all ones; go to `BCAST`.
- `BCAST`: `operand_valid`=pending. Clear bit m when `operand_ready[m]` is 1. Go to `COLLECT` once the mask would be zero.
- `COLLECT`: `product_ready[m]`=1 until product m is captured. Capture `product_data[m]` on transfer. Go to `OUT` when all M are captured.
- `OUT`: `output_valid`=1 and `output_data` stable. On transfer, go to `DLOAD` if `node_train` is set, else `IDLE`.
- `DLOAD`: `delta_in_ready`=1. On transfer, latch into `delta_data`, set pending mask to all ones, go to `DSEND`.
- `DSEND`: same rule as `BCAST`, using `delta_valid`/`delta_ready`. Go to `GATHER` when done.
- `GATHER`: same rule as `COLLECT`, using the feedback channel; captures an `[M][N]` array.
- `SUM`: counter m runs 0..M-1, one node per cycle. `acc[n] += fb[m][n]`, where `acc` is signed, 16+clog2(M)+1 bits wide and cleared on entry. After m=M-1, saturate each `acc[n]` to `[-32768, 32767]` into `error_data`. Go to `ERR`.
- `ERR`: `error_valid`=1. On transfer, go to `IDLE`.
- Per-node handshakes complete in any order and at any time within their state. Bits already cleared are never reasserted.

## Timing
- Reset values:
  - all per-node valids/readies, `output_valid`, `delta_in_ready` and `error_valid` are 0;
  - `input_ready`=1, since state resets to `IDLE`;
  - `operand_data`, `delta_data`, `output_data`, `error_data` and `node_train` are 0.
- Reset mid-operation returns to `IDLE` asynchronously. Pending masks, captures and accumulators clear; nothing is replayed.
- All readies are decoded from registered state and mask; no combinational path from valid to ready. Valids are registered or decoded from state.
- Minimum latency with every node ready immediately:
  - input transfer at cycle 0;
  - `operand_valid` at cycle 1;
  - `COLLECT` at cycle 2;
  - `output_valid` one cycle after the last product transfer.
- `SUM` takes exactly M cycles. `error_valid` rises the cycle after the last `SUM` cycle.
- Valid outputs hold until their transfer, and data holds stable while valid is 1.

## Structure
- Package `layer_pkg`: `word_t` (logic signed [15:0]), `byte_t` (logic [7:0]), state enum `layer_state_t`, and a saturation function `sat16`.
- Sub-module `handshake_fanout #(M)`: pending-mask broadcast of one payload to M ready/valid sinks, with load, valid-vector and done outputs. Instantiated twice, for `BCAST` and `DSEND`.

## Test plan
- M=2, N=2, both nodes ready immediately; input {0x10,0x20}, train=0; nodes return products 0x0100 and 0xFF00 -> `output_data`={0x0100,0xFF00}, then back to `IDLE`; `delta_in_ready` never asserts.
- Staggered readies: node1 asserts `operand_ready` 3 cycles after node0 -> `operand_valid[0]` drops after 1 cycle; `operand_valid[1]` holds 4 cycles; `COLLECT` entered only after both.
- train=1; delta_in={0x0040,0xFFC0}; feedback node0={100,200}, node1={50,-300} -> `error_data`={150,-100}.
- Saturation: feedback node0={30000,-30000}, node1={10000,-10000} -> `error_data`={32767,-32768}.
- `output_ready` held 0 for 5 cycles -> `output_valid` and `output_data` stable throughout; single transfer when released.
- `reset` asserted low during `GATHER` -> all valids/readies 0 immediately; after release `input_ready`=1 and a fresh transaction completes normally.
